// File: rtl/wksg_score_pkg.sv
// Package wksg_pkg: shared types and default constants for the wksg scorekeeper.
//   state_t        : scorekeeper FSM state (IDLE/PLAY/DONE_X/DONE_Y), 2 bits
//   WKSG_CNT_W     : default score counter width
//   WKSG_WIN_SCORE : default number of points needed to win
package wksg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    DONE_X = 2'd2,
    DONE_Y = 2'd3
  } state_t;

  localparam int unsigned WKSG_CNT_W     = 4;
  localparam int unsigned WKSG_WIN_SCORE = 5;

endpackage

// File: rtl/wksg_score_if.sv
// wksg_score_if: control/signal/status bundle between the top level and the
// wksg scorekeeper.
//   master : drives start, clr, sx, sy; observes scores and status
//   slave  : the scorekeeper itself
//   start, clr      : control pulses
//   sx, sy          : side signals from wksg
//   score_x/score_y : per-side points (CNT_W bits)
//   win_x/win_y     : winner levels
//   tie             : simultaneous-edge pulse
//   playing         : game in progress
interface wksg_score_if
  import wksg_pkg::*;
#(
  parameter int unsigned CNT_W = WKSG_CNT_W
) ();

  logic             start;
  logic             clr;
  logic             sx;
  logic             sy;
  logic [CNT_W-1:0] score_x;
  logic [CNT_W-1:0] score_y;
  logic             win_x;
  logic             win_y;
  logic             tie;
  logic             playing;

  modport master (
    output start, clr, sx, sy,
    input  score_x, score_y, win_x, win_y, tie, playing
  );

  modport slave (
    input  start, clr, sx, sy,
    output score_x, score_y, win_x, win_y, tie, playing
  );

endinterface

// File: rtl/wksg_score_edge.sv
// wksg_edge: rising-edge detector, one history flop plus an AND.
//   clk  : system clock
//   rst  : asynchronous active-high reset (history cleared)
//   d    : synchronous input level
//   rise : high in the cycle where d is 1 and was 0 on the previous cycle
module wksg_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

  assign rise = d & ~q;

endmodule

// File: rtl/wksg_score.sv
// wksg_score: scorekeeper downstream of the wksg generator. Rising edges on
// sx/sy score points for side X/Y; first side to reach WIN_SCORE wins and the
// scores freeze until clr.
//   clk : system clock, rst : asynchronous active-high reset
//   bus : wksg_score_if.slave (start, clr, sx, sy in; scores/win/tie/playing out)
// Optional feature macro WKSG_SCORE_LOCKOUT_EN: after every point a LOCK_CYC
// cycle lockout suppresses further edges (no score, no tie).
module wksg_score
  import wksg_pkg::*;
#(
  parameter int unsigned CNT_W     = WKSG_CNT_W,
  parameter int unsigned WIN_SCORE = WKSG_WIN_SCORE,
  parameter int unsigned LOCK_CYC  = 8
) (
  input  logic        clk,
  input  logic        rst,
  wksg_score_if.slave bus
);

  if (WIN_SCORE < 1 || WIN_SCORE > (2**CNT_W) - 1 || LOCK_CYC < 1) begin : g_bad_cfg
    $error("wksg_score: illegal WIN_SCORE/CNT_W/LOCK_CYC combination");
  end

  state_t           state;
  logic [CNT_W-1:0] score_x;
  logic [CNT_W-1:0] score_y;
  logic [CNT_W-1:0] nx_x;
  logic [CNT_W-1:0] nx_y;
  logic             ex;
  logic             ey;
  logic             armed;
  logic             pt_x;
  logic             pt_y;
  logic             in_play;

  wksg_edge u_edge_x (.clk(clk), .rst(rst), .d(bus.sx), .rise(ex));
  wksg_edge u_edge_y (.clk(clk), .rst(rst), .d(bus.sy), .rise(ey));

`ifdef WKSG_SCORE_LOCKOUT_EN
  localparam int unsigned LOCK_W = $clog2(LOCK_CYC + 1);
  logic [LOCK_W-1:0] lock_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               lock_cnt <= '0;
    else if (bus.clr || state == IDLE)     lock_cnt <= '0;
    else if (pt_x || pt_y)                 lock_cnt <= LOCK_W'(LOCK_CYC);
    else if (lock_cnt != '0)               lock_cnt <= lock_cnt - 1'b1;
  end

  assign armed = (lock_cnt == '0);
`else
  assign armed = 1'b1;
`endif

  assign in_play = (state == PLAY);
  assign pt_x    = in_play & armed & ex & ~ey;
  assign pt_y    = in_play & armed & ey & ~ex;
  assign nx_x    = score_x + 1'b1;
  assign nx_y    = score_y + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      score_x <= '0;
      score_y <= '0;
    end else if (bus.clr) begin
      state   <= IDLE;
      score_x <= '0;
      score_y <= '0;
    end else begin
      case (state)
        IDLE: begin
          score_x <= '0;
          score_y <= '0;
          if (bus.start) state <= PLAY;
        end
        PLAY: begin
          if (pt_x) begin
            score_x <= nx_x;
            if (nx_x == CNT_W'(WIN_SCORE)) state <= DONE_X;
          end else if (pt_y) begin
            score_y <= nx_y;
            if (nx_y == CNT_W'(WIN_SCORE)) state <= DONE_Y;
          end
        end
        DONE_X, DONE_Y: ;
      endcase
    end
  end

  assign bus.score_x = score_x;
  assign bus.score_y = score_y;
  assign bus.win_x   = (state == DONE_X);
  assign bus.win_y   = (state == DONE_Y);
  assign bus.playing = in_play;
  // tie reflects the edge being sampled this cycle, so it is combinational.
  assign bus.tie     = in_play & armed & ex & ey;

endmodule

// File: tb/tb_wksg_score.sv
// tb_wksg_score: directed vector table plus hand-written multi-cycle
// sequences for wksg_score (CNT_W=4, WIN_SCORE=5, LOCK_CYC=8).
module tb_wksg_score;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wksg_score_if #(.CNT_W(4)) bus ();

  wksg_score #(.CNT_W(4), .WIN_SCORE(5), .LOCK_CYC(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        st;
    logic        cl;
    logic        x;
    logic        y;
    int unsigned sx;
    int unsigned sy;
    logic        wx;
    logic        wy;
    logic        tie;
    logic        ply;
  } vec_t;

  localparam int NV = 30;
  vec_t tv [NV];

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;
  logic        tie_pre;

`ifdef WKSG_SCORE_LOCKOUT_EN
  localparam int unsigned EXP_LOCK = 2;
`else
  localparam int unsigned EXP_LOCK = 3;
`endif

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Drive at the falling edge, sample tie before the rising edge, and return
  // shortly after the rising edge so registered outputs can be checked.
  task automatic step(input logic st, input logic cl, input logic x, input logic y);
    @(negedge clk);
    bus.start = st;
    bus.clr   = cl;
    bus.sx    = x;
    bus.sy    = y;
    #1 tie_pre = bus.tie;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int unsigned sx, input int unsigned sy,
                         input logic wx, input logic wy, input logic ply);
    chk({tag, ".score_x"}, 32'(bus.score_x), sx);
    chk({tag, ".score_y"}, 32'(bus.score_y), sy);
    chk({tag, ".win_x"},   32'(bus.win_x),   32'(wx));
    chk({tag, ".win_y"},   32'(bus.win_y),   32'(wy));
    chk({tag, ".playing"}, 32'(bus.playing), 32'(ply));
  endtask

  initial begin
    //           st cl x  y   sx sy wx wy tie ply
    tv[0]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0, 1};
    tv[1]  = '{0, 0, 1, 0,  1, 0, 0, 0, 0, 1};
    tv[2]  = '{0, 0, 0, 0,  1, 0, 0, 0, 0, 1};
    tv[3]  = '{0, 0, 1, 0,  2, 0, 0, 0, 0, 1};
    tv[4]  = '{0, 0, 0, 0,  2, 0, 0, 0, 0, 1};
    tv[5]  = '{0, 0, 1, 0,  3, 0, 0, 0, 0, 1};
    tv[6]  = '{0, 0, 0, 0,  3, 0, 0, 0, 0, 1};
    tv[7]  = '{0, 0, 1, 0,  4, 0, 0, 0, 0, 1};
    tv[8]  = '{0, 0, 0, 0,  4, 0, 0, 0, 0, 1};
    tv[9]  = '{0, 0, 1, 0,  5, 0, 1, 0, 0, 0};
    tv[10] = '{0, 0, 0, 1,  5, 0, 1, 0, 0, 0};
    tv[11] = '{0, 0, 0, 0,  5, 0, 1, 0, 0, 0};
    tv[12] = '{1, 0, 0, 0,  5, 0, 1, 0, 0, 0};
    tv[13] = '{0, 1, 0, 0,  0, 0, 0, 0, 0, 0};
    tv[14] = '{1, 0, 0, 0,  0, 0, 0, 0, 0, 1};
    tv[15] = '{0, 0, 1, 1,  0, 0, 0, 0, 1, 1};
    tv[16] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 1};
    tv[17] = '{0, 0, 0, 1,  0, 1, 0, 0, 0, 1};
    tv[18] = '{0, 0, 0, 1,  0, 1, 0, 0, 0, 1};
    tv[19] = '{0, 0, 1, 1,  1, 1, 0, 0, 0, 1};
    tv[20] = '{1, 0, 0, 0,  1, 1, 0, 0, 0, 1};
    tv[21] = '{0, 0, 0, 1,  1, 2, 0, 0, 0, 1};
    tv[22] = '{0, 0, 0, 0,  1, 2, 0, 0, 0, 1};
    tv[23] = '{0, 0, 0, 1,  1, 3, 0, 0, 0, 1};
    tv[24] = '{0, 0, 0, 0,  1, 3, 0, 0, 0, 1};
    tv[25] = '{0, 0, 0, 1,  1, 4, 0, 0, 0, 1};
    tv[26] = '{0, 0, 0, 0,  1, 4, 0, 0, 0, 1};
    tv[27] = '{0, 0, 0, 1,  1, 5, 0, 1, 0, 0};
    tv[28] = '{0, 0, 1, 0,  1, 5, 0, 1, 0, 0};
    tv[29] = '{0, 1, 0, 0,  0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    bus.sx    = 1'b0;
    bus.sy    = 1'b0;
    #1;
    chk_all("reset", 0, 0, 1'b0, 1'b0, 1'b0);
    chk("reset.tie", 32'(bus.tie), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(tv[i].st, tv[i].cl, tv[i].x, tv[i].y);
      chk($sformatf("v%0d.tie", i), 32'(tie_pre), 32'(tv[i].tie));
      chk_all($sformatf("v%0d", i), tv[i].sx, tv[i].sy, tv[i].wx, tv[i].wy, tv[i].ply);
    end

    // Asynchronous reset mid-game with score_x=3, observed before any clock edge.
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    chk("pre_rst.score_x", 32'(bus.score_x), 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 1, 0);
    chk_all("post_rst_idle", 0, 0, 1'b0, 1'b0, 1'b0);

    // Level already high at start, then held: only a fresh rise scores.
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    chk_all("held_start", 0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
    chk("held_pre.score_x", 32'(bus.score_x), 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("held_rise.score_x", 32'(bus.score_x), 1);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
    chk("held10.score_x", 32'(bus.score_x), 1);

    // clr beats a simultaneous winning-candidate edge at score_x=4.
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    chk("clr_pre.score_x", 32'(bus.score_x), 4);
    step(0, 1, 1, 0);
    chk_all("clr_prio", 0, 0, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 0);
    chk("clr_after.win_x", 32'(bus.win_x), 0);

    // Edges at relative cycles 0, 3 and 9.
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 0, (i == 0 || i == 3 || i == 9), 0);
    chk("lockout.score_x", 32'(bus.score_x), EXP_LOCK);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
